rv_wb_uart_tx: RTL



---
 rtl/rv_wb_uart_tx_if.sv | 21 ++
 rtl/rv_wb_uart_tx.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/rv_wb_uart_tx_if.sv
// Wishbone classic bus bundle between the core data-bus master and the UART TX slave.
interface rv_wb_uart_tx_if;
    logic [31:0] i_wb_adr;
    logic [31:0] i_wb_dat;
    logic [31:0] o_wb_dat;
    logic        i_wb_we;
    logic [3:0]  i_wb_sel;
    logic        i_wb_stb;
    logic        i_wb_cyc;
    logic        o_wb_ack;

    modport slave (
        input  i_wb_adr, i_wb_dat, i_wb_we, i_wb_sel, i_wb_stb, i_wb_cyc,
        output o_wb_dat, o_wb_ack
    );

    modport master (
        output i_wb_adr, i_wb_dat, i_wb_we, i_wb_sel, i_wb_stb, i_wb_cyc,
        input  o_wb_dat, o_wb_ack
    );
endinterface

// File: rtl/rv_wb_uart_tx.sv
// Wishbone classic UART transmitter: software bytes queue in a FIFO and leave as 8N1,
// LSB first, at a programmable bit rate; o_irq is high once everything has been sent.
module rv_wb_uart_tx #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd867
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    rv_wb_uart_tx_if.slave wb,
    output logic           o_tx,
    output logic           o_irq
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    tx_state_t     state_r;
    logic [7:0]    fifo_mem_r [FIFO_DEPTH];
    logic [CW-1:0] wr_ptr_r;
    logic [CW-1:0] rd_ptr_r;
    logic          ack_r;
    logic [31:0]   rdata_r;
    logic          ovf_r;
    logic [15:0]   div_r;
    logic [15:0]   baud_cnt_r;
    logic [2:0]    bit_cnt_r;
    logic [7:0]    shift_r;
    logic          tx_r;
    logic          irq_r;

    logic          request_s;
    logic          wr_s;
    logic [1:0]    reg_sel_s;
    logic [CW-1:0] count_s;
    logic          empty_s;
    logic          full_s;
    logic          busy_s;
    logic          push_s;
    logic          drop_s;
    logic          ovf_clr_s;
    logic          pop_s;
    logic [31:0]   status_s;
    logic [31:0]   rd_mux_s;
    logic          unused_s;

    // Bus decode, FIFO flags and read-data mux; full is judged before any same-cycle pop.
    always_comb begin
        request_s = wb.i_wb_cyc & wb.i_wb_stb & ~ack_r;
        wr_s      = request_s & wb.i_wb_we;
        reg_sel_s = wb.i_wb_adr[3:2];
        count_s   = wr_ptr_r - rd_ptr_r;
        empty_s   = (wr_ptr_r == rd_ptr_r);
        full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        busy_s    = (state_r != ST_IDLE);
        push_s    = wr_s & (reg_sel_s == REG_DATA) & wb.i_wb_sel[0] & ~full_s;
        drop_s    = wr_s & (reg_sel_s == REG_DATA) & wb.i_wb_sel[0] & full_s;
        ovf_clr_s = wr_s & (reg_sel_s == REG_STATUS) & wb.i_wb_sel[0] & wb.i_wb_dat[3];
        pop_s     = (state_r == ST_IDLE) & ~empty_s;
        status_s  = {{(28 - CW){1'b0}}, count_s, ovf_r, empty_s, full_s, busy_s};
        case (reg_sel_s)
            REG_STATUS: rd_mux_s = status_s;
            REG_DIV:    rd_mux_s = {16'd0, div_r};
            default:    rd_mux_s = 32'd0;
        endcase
    end

    // Bus acknowledge, registered read data, sticky overflow and divider register.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            ack_r   <= 1'b0;
            rdata_r <= 32'd0;
            ovf_r   <= 1'b0;
            div_r   <= DIV_RESET;
        end else begin
            ack_r <= request_s;
            if (request_s && !wb.i_wb_we) begin
                rdata_r <= rd_mux_s;
            end else begin
                rdata_r <= 32'd0;
            end
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr_s) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
            if (wr_s && (reg_sel_s == REG_DIV)) begin
                if (wb.i_wb_sel[0]) begin
                    div_r[7:0] <= wb.i_wb_dat[7:0];
                end
                if (wb.i_wb_sel[1]) begin
                    div_r[15:8] <= wb.i_wb_dat[15:8];
                end
            end
        end
    end

    // Circular TX FIFO; the extra pointer bit separates full from empty.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wr_ptr_r <= {CW{1'b0}};
            rd_ptr_r <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r[AW-1:0]] <= wb.i_wb_dat[7:0];
                wr_ptr_r                     <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Serialiser FSM; the baud counter reloads from the live DIV at every bit boundary.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_r    <= ST_IDLE;
            baud_cnt_r <= 16'd0;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'd0;
            tx_r       <= 1'b1;
            irq_r      <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        shift_r    <= fifo_mem_r[rd_ptr_r[AW-1:0]];
                        bit_cnt_r  <= 3'd0;
                        baud_cnt_r <= div_r;
                        state_r    <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_cnt_r == 16'd0) begin
                        baud_cnt_r <= div_r;
                        state_r    <= ST_DATA;
                    end else begin
                        baud_cnt_r <= baud_cnt_r - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (baud_cnt_r == 16'd0) begin
                        baud_cnt_r <= div_r;
                        shift_r    <= {1'b0, shift_r[7:1]};
                        if (bit_cnt_r == 3'd7) begin
                            state_r <= ST_STOP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (baud_cnt_r == 16'd0) begin
                        state_r <= ST_IDLE;
                    end else begin
                        baud_cnt_r <= baud_cnt_r - 16'd1;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
            case (state_r)
                ST_START: tx_r <= 1'b0;
                ST_DATA:  tx_r <= shift_r[0];
                default:  tx_r <= 1'b1;
            endcase
            irq_r <= empty_s & (state_r == ST_IDLE);
        end
    end

    assign wb.o_wb_ack = ack_r;
    assign wb.o_wb_dat = rdata_r;
    assign o_tx        = tx_r;
    assign o_irq       = irq_r;
    assign unused_s    = ^{wb.i_wb_adr[31:4], wb.i_wb_adr[1:0], wb.i_wb_dat[31:16], wb.i_wb_sel[3:2]};
endmodule
